// File: rtl/seradd_pkg.sv
// seradd_pkg: shared FSM encoding, nibble width and counter sizing for the nibble serial adder
package seradd_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
  localparam int NIB_W = 4;
  function automatic int cnt_w(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction
endpackage

// File: rtl/nibble_add_slice.sv
// nibble_add_slice: combinational 4-bit add-with-carry shared by every nibble of an operation
module nibble_add_slice
  import seradd_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, ci};
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder processing one nibble per clock, valid/ready on both sides
// Optional signed-overflow output ovf is built when SERADD_OVF_EN is defined.
module nibble_serial_adder
  import seradd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERADD_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int CW = cnt_w(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);
  state_t state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CW-1:0] cnt;
  logic [NIB_W-1:0] s;
  logic co;
  nibble_add_slice u_slice (
    .a (a_sr[NIB_W-1:0]),
    .b (b_sr[NIB_W-1:0]),
    .ci(cout),
    .s (s),
    .co(co)
  );
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  // cout doubles as the running inter-nibble carry; it is only meaningful once out_valid is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      cnt   <= '0;
`ifdef SERADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sr  <= ina;
          b_sr  <= inb;
          cout  <= cin;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          cout <= co;
          sum  <= (sum >> NIB_W) | (WIDTH'(s) << (WIDTH - NIB_W));
          a_sr <= a_sr >> NIB_W;
          b_sr <= b_sr >> NIB_W;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
`ifdef SERADD_OVF_EN
            ovf   <= (a_sr[NIB_W-1] == b_sr[NIB_W-1]) & (s[NIB_W-1] != a_sr[NIB_W-1]);
`endif
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed self-checking bench for the 16-bit nibble serial adder
module tb_nibble_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [15:0] ina = '0;
  logic [15:0] inb = '0;
  logic cin = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [15:0] sum;
  logic cout;
`ifdef SERADD_OVF_EN
  logic ovf;
`endif
  int checks = 0;
  int errors = 0;
  int n;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ina      (ina),
    .inb      (inb),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
`ifdef SERADD_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic [15:0] es, input logic ec, input logic eo, input int stall);
    int cyc;
    @(negedge clk);
    ina = a; inb = b; cin = c; in_valid = 1'b1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(cyc);
    chk({tag, "_latency"}, 32'(cyc), 32'd4);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
`ifdef SERADD_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo) $display("note: %s expects overflow, flag not built", tag);
`endif
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_stall_sum"}, 32'(sum), 32'(es));
      chk({tag, "_stall_cout"}, 32'(cout), 32'(ec));
      chk({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
`ifdef SERADD_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;

    do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    do_op("cin_only", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 0);
    do_op("mixed", 16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0, 0);
    do_op("all_ones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);
    do_op("stall", 16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 10);

    // busy ignore: second pair held on in_valid during RUN, accepted only after returning to IDLE
    @(negedge clk);
    ina = 16'h1111; inb = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    ina = 16'h5555; inb = 16'h5555;
    chk("busy_in_ready", 32'(in_ready), 32'd0);
    wait_done(n);
    chk("busy_latency", 32'(n), 32'd4);
    chk("busy_sum", 32'(sum), 32'h3333);
    chk("busy_cout", 32'(cout), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("busy_idle_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("busy_second_accept", 32'(in_ready), 32'd0);
    wait_done(n);
    chk("busy_second_latency", 32'(n), 32'd4);
    chk("busy_second_sum", 32'(sum), 32'hAAAA);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // reset after the second RUN cycle, while sum holds partial nibbles
    @(negedge clk);
    ina = 16'h1234; inb = 16'h1111; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 0);

`ifdef SERADD_OVF_EN
    do_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    do_op("ovf_neg", 16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, 0);
    do_op("ovf_none", 16'h4000, 16'h3FFF, 1'b0, 16'h7FFF, 1'b0, 1'b0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit adder that splits each operand pair into 4-bit nibbles and processes one nibble per clock through a single 4-bit add-with-carry slice, registering the carry between nibbles. It sits upstream of result consumers that accept a valid/ready stream. It trades throughput for area when a full-width carry chain is too large for the target timing.

## Interface
- `WIDTH`, default 16: operand and sum width in bits. Must be a multiple of 4 and at least 4.
- `NIBBLES`, derived as WIDTH/4: number of add cycles per operation. Not user-overridable.

Ports:
- `clk`  input  1  single clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  operand pair present.
- `in_ready`  output  1  block can accept operands.
- `ina`  input  WIDTH  operand A, unsigned.
- `inb`  input  WIDTH  operand B, unsigned.
- `cin`  input  1  carry into nibble 0.
- `out_valid`  output  1  result present.
- `out_ready`  input  1  consumer accepts the result.
- `sum`  output  WIDTH  result bits [WIDTH-1:0].
- `cout`  output  1  carry out of the top nibble.
- `ovf`  output  1  signed overflow. Present only with SERADD_OVF_EN.

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: capture `ina`, `inb` and `cin` into the A and B shift registers and the carry register, clear the nibble counter, and go to RUN.
- **RUN**
  - `in_ready`=0. `in_valid` is ignored and operands are not sampled.
  - Each cycle, compute {c, s} = A[3:0] + B[3:0] + carry (5-bit result).
  - carry ← c.
  - The sum register shifts right by 4 and s is inserted at bits [WIDTH-1:WIDTH-4].
  - A and B shift right by 4.
  - Counter increments. When the counter reaches NIBBLES-1 on this cycle's add, go to DONE.
- **DONE**
  - `out_valid`=1. `sum` holds the full result and `cout` holds the final carry.
  - Both stay stable while `out_valid`=1 and `out_ready`=0.
  - On `out_ready`: go to IDLE.
  - No new operands are accepted in the same cycle (`in_ready`=0 in DONE).
- **Arithmetic**: {cout, sum} equals ina + inb + cin, computed modulo 2^(WIDTH+1). No truncation other than WIDTH+1 bits.
- **WIDTH=4 (NIBBLES=1)**: RUN lasts exactly one cycle.

## Timing
- **Reset values**:
  - `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0.
  - `in_ready`=1, since the FSM is in IDLE during and after reset.
- **Reset mid-operation**: asynchronous assertion aborts RUN or DONE immediately. All registers are cleared and the FSM returns to IDLE. No partial result is ever presented.
- **Acceptance**: a handshake completes on a rising edge with `in_valid` & `in_ready` high. Call that edge T0.
- **Latency**:
  - RUN occupies edges T0+1 … T0+NIBBLES.
  - `out_valid` rises after edge T0+NIBBLES.
  - With WIDTH=16, `out_valid` is first high in the cycle after the 4th post-accept edge.
- **Output handshake**: a transfer completes on the edge where `out_valid` & `out_ready` are both high. `in_ready` returns to 1 in the following cycle.
- **Throughput**: one operation every NIBBLES+2 cycles when the consumer never stalls.
- **Output timing**: `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from inputs to outputs.

## Configuration
- **Macro**: `SERADD_OVF_EN`.
- **With the macro defined**:
  - The `ovf` port exists.
  - In the top-nibble cycle, register ovf = (A[3]==B[3]) & (s[3]!=A[3]), i.e. signed two's-complement overflow of the full-width add.
  - `ovf` is valid and stable alongside `sum` in DONE and resets to 0.
- **Without the macro**: the `ovf` port and its register are absent. All other behaviour is identical.

## Structure
- **Shared package `seradd_pkg`**:
  - FSM state enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Constant NIB_W=4.
  - Function computing the counter width: $clog2(NIBBLES), with a minimum of 1.
- **Sub-module `nibble_add_slice`**: purely combinational 4-bit add-with-carry (ports a[3:0], b[3:0], ci, s[3:0], co). It is instantiated once. The FSM, shift registers and counter live in the top module.

## Test plan
All scenarios use WIDTH=16.
- **Carry ripple**: ina=16'hFFFF, inb=16'h0001, cin=0 → sum=16'h0000, cout=1. `out_valid` appears exactly 4 cycles after accept.
- **Carry-in only**: ina=16'h1234, inb=16'h4321, cin=1 → sum=16'h5556, cout=0.
- **Output stall**: out_ready=0 for 10 cycles in DONE. Required: sum, cout and out_valid stay stable and in_ready stays 0 throughout. When out_ready=1, in_ready=1 the next cycle.
- **Busy ignore**: pulse in_valid with different operands during RUN → the result is unaffected. The second operand pair is accepted only once back in IDLE.
- **Mid-RUN reset**: assert rst_n=0 after the 2nd RUN cycle. Required: immediately out_valid=0, sum=0, cout=0, in_ready=1. A following add of 16'h00FF + 16'h0001 → 16'h0100.
- **Overflow flag (SERADD_OVF_EN defined)**:
  - 16'h7FFF + 16'h0001 → ovf=1, sum=16'h8000.
  - 16'h8000 + 16'hFFFF → ovf=1, cout=1, sum=16'h7FFF.
